// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings, FSM
// states and the fixed operand width / result latency.
package mips_muldiv_pkg;

    localparam int DW  = 32;
    localparam int LAT = DW + 2;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic isIterOp(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction for the unsigned-magnitude results: negates the
// 64-bit product, or the quotient and remainder independently.
module muldiv_signfix #(
    parameter int DW = 32
) (
    input  logic [2*DW-1:0] i_acc,
    input  logic            i_isMul,
    input  logic            i_qNeg,
    input  logic            i_rNeg,
    output logic [DW-1:0]   o_hi,
    output logic [DW-1:0]   o_lo
);

    logic [2*DW-1:0] w_prod;
    logic [DW-1:0]   w_quot;
    logic [DW-1:0]   w_rem;

    // For a divide the accumulator holds {remainder, quotient}.
    assign w_prod = i_qNeg ? -i_acc : i_acc;
    assign w_quot = i_qNeg ? -i_acc[DW-1:0] : i_acc[DW-1:0];
    assign w_rem  = i_rNeg ? -i_acc[2*DW-1:DW] : i_acc[2*DW-1:DW];

    assign o_hi = i_isMul ? w_prod[2*DW-1:DW] : w_rem;
    assign o_lo = i_isMul ? w_prod[DW-1:0]    : w_quot;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO for the MIPS EX stage.
// Optional macro MULDIV_EARLY_DIVZERO_EN: divide by zero bypasses CALC.
module muldiv_unit #(
    parameter int DW    = 32,
    parameter int STEPS = DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);
    import mips_muldiv_pkg::*;

    localparam int CW = $clog2(STEPS + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_pend;
    logic            r_isMul;
    logic            r_qNeg;
    logic            r_rNeg;
    logic            r_divz;
    logic            r_done;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_opA;
    logic [DW-1:0]   r_opB;
    logic [DW-1:0]   r_aRaw;
    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;
    logic [2*DW-1:0] r_acc;

    logic            w_accept;
    logic            w_aNeg;
    logic            w_bNeg;
    logic            w_isMul;
    logic [DW-1:0]   w_aMag;
    logic [DW-1:0]   w_bMag;
    logic [DW:0]     w_mulSum;
    logic [2*DW-1:0] w_mulNext;
    logic            w_divGe;
    logic [DW-1:0]   w_divDiff;
    logic [2*DW-1:0] w_divNext;
    logic            w_fixWrite;
    logic [DW-1:0]   w_fixHi;
    logic [DW-1:0]   w_fixLo;

    // A request is only taken from a quiet IDLE; flush always wins over start.
    assign w_accept = (r_state == ST_IDLE) && !r_pend && start && !flush;
    assign w_isMul  = (op == OP_MULT) || (op == OP_MULTU);
    assign w_aNeg   = isSignedOp(op) && a[DW-1];
    assign w_bNeg   = isSignedOp(op) && b[DW-1];
    assign w_aMag   = w_aNeg ? -a : a;
    assign w_bMag   = w_bNeg ? -b : b;

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    assign w_mulSum  = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_opA} : '0);
    assign w_mulNext = {w_mulSum, r_acc[DW-1:1]};

    // Divide: accumulator is {partial remainder, dividend/quotient bits}.
    assign w_divGe   = r_acc[2*DW-1:DW-1] >= {1'b0, r_opB};
    assign w_divDiff = r_acc[2*DW-2:DW-1] - r_opB;
    assign w_divNext = w_divGe ? {w_divDiff, r_acc[DW-2:0], 1'b1}
                               : {r_acc[2*DW-2:0], 1'b0};

    assign w_fixWrite = (r_state == ST_FIX) && !flush;

    muldiv_signfix #(
        .DW(DW)
    ) u_signfix (
        .i_acc   (r_acc),
        .i_isMul (r_isMul),
        .i_qNeg  (r_qNeg),
        .i_rNeg  (r_rNeg),
        .o_hi    (w_fixHi),
        .o_lo    (w_fixLo)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_pend && !flush) begin
`ifdef MULDIV_EARLY_DIVZERO_EN
                    w_next = r_divz ? ST_FIX : ST_CALC;
`else
                    w_next = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (flush) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, iteration and HI/LO update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend  <= 1'b0;
            r_isMul <= 1'b0;
            r_qNeg  <= 1'b0;
            r_rNeg  <= 1'b0;
            r_divz  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_aRaw  <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= w_fixWrite;
            r_pend <= w_accept && isIterOp(op);
            if (w_accept && isIterOp(op)) begin
                r_isMul <= w_isMul;
                r_qNeg  <= w_aNeg ^ w_bNeg;
                r_rNeg  <= w_aNeg;
                r_divz  <= !w_isMul && (b == '0);
                r_cnt   <= CW'(STEPS);
                r_aRaw  <= a;
                r_opA   <= w_aMag;
                r_opB   <= w_bMag;
                r_acc   <= w_isMul ? {{DW{1'b0}}, w_bMag} : {{DW{1'b0}}, w_aMag};
            end
            if (w_accept && (op == OP_MTHI)) begin
                r_hi <= a;
            end
            if (w_accept && (op == OP_MTLO)) begin
                r_lo <= a;
            end
            if (r_state == ST_CALC) begin
                r_acc <= r_isMul ? w_mulNext : w_divNext;
                r_cnt <= r_cnt - CW'(1);
            end
            // Divide by zero reports the original dividend bits, whatever the sign.
            if (w_fixWrite) begin
                if (r_divz) begin
                    r_hi <= r_aRaw;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_fixHi;
                    r_lo <= w_fixLo;
                end
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: timeline model of results and
// handshake compared every cycle, plus directed literal checks.
module tb_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;
    bit running    = 1'b1;

    // Model state, advanced on every clock edge from the inputs seen there.
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic [63:0] mRes = '0;
    bit          mInflight = 1'b0;
    bit          mBusy = 1'b0;
    bit          mDone = 1'b0;
    int          mCyc = 0;
    int          mAcceptCyc = 0;
    int          mDoneCyc = 0;

    muldiv_unit #(
        .DW(32),
        .STEPS(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Architectural result as {hi, lo} from plain arithmetic.
    function automatic logic [63:0] modelResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        int     sx;
        int     sy;
        logic [63:0] r;
        r = '0;
        case (o)
            OP_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                r  = sp;
            end
            OP_MULTU: r = {32'b0, x} * {32'b0, y};
            OP_DIV, OP_DIVU: begin
                if (y == 32'd0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else if (o == OP_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r = {32'd0, 32'h8000_0000};
                end else if (o == OP_DIV) begin
                    sx = x;
                    sy = y;
                    r  = {32'(sx % sy), 32'(sx / sy)};
                end else begin
                    r = {x % y, x / y};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int latencyFor(input logic [2:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_DIVZERO_EN
        if ((o == OP_DIV || o == OP_DIVU) && y == 32'd0) return 2;
`else
        if (y == 32'hDEAD_0000 && o == 3'd7) return 0;
`endif
        return LAT;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mHi = '0;
            mLo = '0;
            mInflight = 1'b0;
            mBusy = 1'b0;
            mDone = 1'b0;
            mCyc = 0;
            mAcceptCyc = 0;
        end else begin
            mCyc++;
            mDone = 1'b0;
            if (mInflight) begin
                if (flush) begin
                    mInflight = 1'b0;
                end else if (mCyc == mDoneCyc) begin
                    {mHi, mLo} = mRes;
                    mDone = 1'b1;
                    mInflight = 1'b0;
                end
            end else if (start && !flush) begin
                if (op >= OP_MULT && op <= OP_DIVU) begin
                    mInflight = 1'b1;
                    mAcceptCyc = mCyc;
                    mRes = modelResult(op, a, b);
                    mDoneCyc = mCyc + latencyFor(op, b);
                end else if (op == OP_MTHI) begin
                    mHi = a;
                end else if (op == OP_MTLO) begin
                    mLo = a;
                end
            end
            mBusy = mInflight && (mCyc > mAcceptCyc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = OP_NOP;
    endtask

    task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eHi, input logic [31:0] eLo, input int eLat);
        int lat;
        int busyCyc;
        bit got;
        applyStimulus(o, x, y);
        lat = 0;
        busyCyc = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) busyCyc++;
            if (done) got = 1'b1;
        end
        checkOutput({name, " done seen"}, 32'(got), 32'd1);
        checkOutput({name, " latency"}, 32'(lat), 32'(eLat));
        checkOutput({name, " busy cycles"}, 32'(busyCyc), 32'(eLat - 1));
        checkOutput({name, " hi"}, hi, eHi);
        checkOutput({name, " lo"}, lo, eLo);
    endtask

    task automatic compareLoop();
        while (running) begin
            @(negedge clk);
            if (!reset && running) begin
                checkOutput("cyc busy", 32'(busy), 32'(mBusy));
                checkOutput("cyc done", 32'(done), 32'(mDone));
                checkOutput("cyc hi", hi, mHi);
                checkOutput("cyc lo", lo, mLo);
            end
        end
    endtask

    task automatic mainFlow();
        int divzLat;
        int doneCnt;
`ifdef MULDIV_EARLY_DIVZERO_EN
        divzLat = 2;
`else
        divzLat = LAT;
`endif
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = OP_NOP;
        a     = '0;
        b     = '0;
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        runOp("MULTU max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
        runOp("MULT -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);
        runOp("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        runOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        runOp("MULT min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34);
        runOp("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34);
        runOp("DIVU 7/0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, divzLat);
        runOp("DIV -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, divzLat);
        runOp("DIV overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34);

        applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0);
        @(negedge clk);
        checkOutput("MTHI hi", hi, 32'h1234_5678);
        checkOutput("MTHI lo", lo, 32'h8000_0000);
        checkOutput("MTHI done", 32'(done), 32'd0);
        checkOutput("MTHI busy", 32'(busy), 32'd0);

        flush = 1'b1;
        applyStimulus(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flushed MTLO lo", lo, 32'h8000_0000);

        applyStimulus(OP_MULTU, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(OP_MULTU, 32'd3, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush busy", 32'(busy), 32'd0);
        checkOutput("flush done", 32'(done), 32'd0);
        checkOutput("flush hi", hi, 32'h1234_5678);
        checkOutput("flush lo", lo, 32'h8000_0000);
        doneCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("no done after flush", 32'(doneCnt), 32'd0);

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd3);
        repeat (19) @(posedge clk);
        #2;
        checkOutput("busy before reset", 32'(busy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        checkOutput("async reset hi", hi, 32'd0);
        checkOutput("async reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        runOp("MULTU 6*7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 34);
        repeat (3) @(negedge clk);
        running = 1'b0;
    endtask

    initial begin
        fork
            mainFlow();
            compareLoop();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
